sdram_write_buffer: RTL
=======================

SDRAM_WRITE_BUFFER -- requirements
Module: sdram_write_buffer

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 32, data word width; ADDRESS_WIDTH, default 21, word address width; DEPTH, default 4, posted-write entries (power of two, 2..16).
REQ-002 clk  input  1  single clock, all logic on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 cpu_address  input  ADDRESS_WIDTH  CPU word address.
REQ-005 cpu_data_in  input  DATA_WIDTH  CPU write data; cpu_data_out  output  DATA_WIDTH  CPU read data.
REQ-006 cpu_req  input  1  CPU request; cpu_nwr  input  DATA_WIDTH/8  active-low byte write enables, all ones = read; cpu_ack  output  1  CPU acknowledge.
REQ-007 mem_address  output  ADDRESS_WIDTH, mem_data_out  output  DATA_WIDTH, mem_nwr  output  DATA_WIDTH/8, mem_req  output  1  request to SDRAM controller.
REQ-008 mem_data_in  input  DATA_WIDTH, mem_ack  input  1  controller read data and acknowledge.

Function
REQ-009 Both ports SHALL use four-phase handshake: req rises, ack rises, req falls, ack falls; a new request SHALL NOT start until ack is low.
REQ-010 CPU write (cpu_req high, cpu_ack low, cpu_nwr not all ones) SHALL push {address, data, nwr} into the FIFO and set cpu_ack on the next edge when count < DEPTH.
REQ-011 Write with count == DEPTH SHALL stall with cpu_ack low; a pop in the same cycle SHALL NOT admit the push (full check uses registered count).
REQ-012 cpu_ack SHALL clear on the first edge with cpu_req low; a request already acknowledged SHALL NOT be pushed or issued twice.
REQ-013 count SHALL be $clog2(DEPTH)+1 bits; simultaneous push and pop SHALL leave count unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-014 Drain FSM states: IDLE, WR_REQ, RD_REQ, RELEASE.
REQ-015 IDLE: pending read eligible per REQ-018 -> RD_REQ; else count != 0 -> WR_REQ with head entry driven on mem_address/mem_data_out/mem_nwr; else stay.
REQ-016 WR_REQ/RD_REQ: mem_req high, outputs stable; on mem_ack high -> RELEASE, mem_req low; WR_REQ pops head on that edge; RD_REQ latches mem_data_in into cpu_data_out and sets cpu_ack on that edge.
REQ-017 RELEASE: wait mem_ack low -> IDLE; minimum two cycles per transaction.
REQ-018 CPU read SHALL be eligible only when count == 0 and FSM in IDLE; reads SHALL take priority over writes pushed in the same cycle.
REQ-019 mem_nwr SHALL be all ones during RD_REQ; mem_address SHALL equal cpu_address latched at read start.
REQ-020 cpu_data_out SHALL hold the last read value until next read completes.

Reset
REQ-021 reset high SHALL immediately clear: cpu_ack=0, mem_req=0, mem_nwr=all ones, mem_address=0, mem_data_out=0, cpu_data_out=0, count=0, pointers=0, FSM=IDLE.
REQ-022 Reset mid-transaction SHALL discard all posted writes; after release the block SHALL wait for mem_ack low before issuing any request.

Configuration
REQ-023 Macro SDRAM_WRITE_BUFFER_READ_BYPASS_EN: defined -> a read SHALL be eligible in IDLE when no valid FIFO entry matches cpu_address, overtaking pending writes; matching read waits until matching entries drain.
REQ-024 Undefined -> REQ-018 applies unchanged and no address comparators SHALL be built.

Verification
REQ-025 Reset, write 0x12345678 to 0x00010, nwr=0 -> cpu_ack next edge; mem_req with address 0x00010, data 0x12345678, nwr=0; count 1 -> 0 on mem_ack.
REQ-026 Hold mem_ack low, issue 5 writes, DEPTH=4 -> first 4 acked, 5th stalls until first pop, then acked; no write lost, order preserved.
REQ-027 Write 0xAABBCCDD to 0x00020 then read 0x00020 -> read mem_req only after write mem_ack cycle completes; cpu_data_out=0xAABBCCDD.
REQ-028 With BYPASS_EN, 3 writes to 0x100-0x102 pending, read 0x200 -> RD_REQ issued before remaining writes; read 0x101 -> waits until 0x101 drained.
REQ-029 Assert reset during WR_REQ with 3 entries -> mem_req low same cycle, count=0, no further mem_req until new CPU request.
REQ-030 cpu_req held high after cpu_ack -> exactly one push; cpu_ack drops one edge after cpu_req falls.

Source files
------------

// File: rtl/sdram_write_buffer.sv
// sdram_write_buffer: posted-write FIFO between a CPU and an SDRAM controller, four-phase handshakes on both sides.
// Optional macro SDRAM_WRITE_BUFFER_READ_BYPASS_EN lets reads overtake pending writes to other addresses.
`default_nettype none

module sdram_write_buffer #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 21,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [ADDRESS_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0]    cpu_data_in,
  output logic [DATA_WIDTH-1:0]    cpu_data_out,
  input  logic                     cpu_req,
  input  logic [DATA_WIDTH/8-1:0]  cpu_nwr,
  output logic                     cpu_ack,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_data_out,
  output logic [DATA_WIDTH/8-1:0]  mem_nwr,
  output logic                     mem_req,
  input  logic [DATA_WIDTH-1:0]    mem_data_in,
  input  logic                     mem_ack
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = DATA_WIDTH / 8;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WR_REQ  = 2'd1;
  localparam logic [1:0] RD_REQ  = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0]    data_mem [DEPTH];
  logic [BW-1:0]            nwr_mem  [DEPTH];

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  logic cpu_is_write;
  logic push;
  logic pop;
  logic read_ok;
  logic rd_start;
  logic rd_done;

  assign cpu_is_write = (cpu_nwr != '1);
  // Full check uses the registered count, so a same-cycle pop never admits a push.
  assign push     = cpu_req && !cpu_ack && cpu_is_write && (count < FULL);
  assign pop      = (state == WR_REQ) && mem_ack;
  assign rd_done  = (state == RD_REQ) && mem_ack;
  assign rd_start = (state == IDLE) && !mem_ack && cpu_req && !cpu_ack
                    && !cpu_is_write && read_ok;

`ifdef SDRAM_WRITE_BUFFER_READ_BYPASS_EN
  logic [DEPTH-1:0] hit;

  // An entry is live when its distance from the read pointer is below count.
  for (genvar i = 0; i < DEPTH; i++) begin : g_match
    logic [PW-1:0] offset;
    assign offset = PW'(i) - rd_ptr;
    assign hit[i] = ({1'b0, offset} < count) && (addr_mem[i] == cpu_address);
  end

  assign read_ok = (count == '0) || (hit == '0);
`else
  assign read_ok = (count == '0);
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= cpu_address;
      data_mem[wr_ptr] <= cpu_data_in;
      nwr_mem[wr_ptr]  <= cpu_nwr;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cpu_ack      <= 1'b0;
      cpu_data_out <= '0;
      mem_req      <= 1'b0;
      mem_address  <= '0;
      mem_data_out <= '0;
      mem_nwr      <= '1;
    end else begin
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end

      if (!cpu_req) begin
        cpu_ack <= 1'b0;
      end else if (push || rd_done) begin
        cpu_ack <= 1'b1;
      end
      if (rd_done) begin
        cpu_data_out <= mem_data_in;
      end

      case (state)
        // Never start a request while the controller still shows ack, including after reset.
        IDLE: begin
          if (!mem_ack) begin
            if (rd_start) begin
              state       <= RD_REQ;
              mem_req     <= 1'b1;
              mem_address <= cpu_address;
              mem_nwr     <= '1;
            end else if (count != '0) begin
              state        <= WR_REQ;
              mem_req      <= 1'b1;
              mem_address  <= addr_mem[rd_ptr];
              mem_data_out <= data_mem[rd_ptr];
              mem_nwr      <= nwr_mem[rd_ptr];
            end
          end
        end
        WR_REQ, RD_REQ: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= RELEASE;
          end
        end
        RELEASE: begin
          if (!mem_ack) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
